// File: rtl/pmod_cls_text_sequencer_pkg.sv
// Shared types, ASCII constants and segment helpers for the Pmod CLS text sequencer.
// Byte selection lives here so the top stays a plain FSM plus datapath.
package pmod_cls_text_sequencer_pkg;

  localparam logic [7:0] ASCII_CLS_ESC            = 8'h1B;
  localparam logic [7:0] ASCII_CLS_BRACKET        = 8'h5B;
  localparam logic [7:0] ASCII_CLS_CHAR_ZERO      = 8'h30;
  localparam logic [7:0] ASCII_CLS_CHAR_ONE       = 8'h31;
  localparam logic [7:0] ASCII_CLS_CHAR_SEMICOLON = 8'h3B;
  localparam logic [7:0] ASCII_CLS_DISP_CLR_CMD   = 8'h6A;
  localparam logic [7:0] ASCII_CLS_CURSOR_POS_CMD = 8'h48;

  typedef logic [127:0] t_pmod_cls_ascii_line_16;
  typedef logic [4:0]   t_pmod_cls_dat_len;
  typedef logic [2:0]   t_cls_seg_idx;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GO    = 3'd2,
    ST_START = 3'd3,
    ST_BUSY  = 3'd4,
    ST_GAP   = 3'd5
  } t_cls_seq_state;

  function automatic t_pmod_cls_dat_len f_seg_len(input t_cls_seg_idx i_seg);
    t_pmod_cls_dat_len w_len;
    case (i_seg)
      3'd0:       w_len = 5'd3;
      3'd1, 3'd3: w_len = 5'd6;
      3'd2, 3'd4: w_len = 5'd16;
      default:    w_len = 5'd0;
    endcase
    return w_len;
  endfunction

  // Segments 1 and 3 are the same cursor command, differing only in the row digit.
  function automatic logic [7:0] f_seg_byte(
    input t_cls_seg_idx            i_seg,
    input logic [3:0]              i_pos,
    input t_pmod_cls_ascii_line_16 i_line1,
    input t_pmod_cls_ascii_line_16 i_line2
  );
    logic [7:0]   w_byte;
    logic [127:0] w_l1_sh;
    logic [127:0] w_l2_sh;
    w_l1_sh = i_line1 << {i_pos, 3'b000};
    w_l2_sh = i_line2 << {i_pos, 3'b000};
    case (i_seg)
      3'd0: begin
        case (i_pos)
          4'd0:    w_byte = ASCII_CLS_ESC;
          4'd1:    w_byte = ASCII_CLS_BRACKET;
          4'd2:    w_byte = ASCII_CLS_DISP_CLR_CMD;
          default: w_byte = 8'h00;
        endcase
      end
      3'd1, 3'd3: begin
        case (i_pos)
          4'd0:    w_byte = ASCII_CLS_ESC;
          4'd1:    w_byte = ASCII_CLS_BRACKET;
          4'd2:    w_byte = (i_seg == 3'd3) ? ASCII_CLS_CHAR_ONE : ASCII_CLS_CHAR_ZERO;
          4'd3:    w_byte = ASCII_CLS_CHAR_SEMICOLON;
          4'd4:    w_byte = ASCII_CLS_CHAR_ZERO;
          4'd5:    w_byte = ASCII_CLS_CURSOR_POS_CMD;
          default: w_byte = 8'h00;
        endcase
      end
      3'd2:    w_byte = w_l1_sh[127:120];
      3'd4:    w_byte = w_l2_sh[127:120];
      default: w_byte = 8'h00;
    endcase
    return w_byte;
  endfunction

endpackage

// File: rtl/pmod_cls_text_sequencer.sv
// Streams clear/home/line1/row1/line2 into the Pmod CLS SPI driver TX FIFO,
// one go strobe per segment, with an idle gap after each SPI transaction.
module pmod_cls_text_sequencer #(
  parameter int MIN_GAP_CYCLES = 200
) (
  input  logic         i_clk_20mhz,
  input  logic         i_rst_20mhz,
  input  logic         i_cls_upd,
  input  logic [127:0] i_dat_ascii_line1,
  input  logic [127:0] i_dat_ascii_line2,
  output logic         o_cls_ready,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_enqueue,
  output logic         o_go_stand,
  output logic [4:0]   o_tx_len,
  input  logic         i_tx_ready,
  input  logic         i_spi_idle
);
  import pmod_cls_text_sequencer_pkg::*;

  localparam int               GAP_W    = $clog2(MIN_GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP_CYCLES - 1);

  t_cls_seq_state          r_state;
  t_cls_seq_state          w_state_nxt;
  t_cls_seg_idx            r_seg;
  logic [4:0]              r_idx;
  t_pmod_cls_ascii_line_16 r_line1;
  t_pmod_cls_ascii_line_16 r_line2;
  t_pmod_cls_dat_len       r_tx_len;
  logic [GAP_W-1:0]        r_gap_cnt;
  logic                    w_enq;
  logic                    w_last;
  logic [7:0]              w_data;

  // State register
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, enqueue handshake and byte mux
  always_comb begin
    w_state_nxt = r_state;
    w_enq       = 1'b0;
    w_data      = 8'h00;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cls_upd) w_state_nxt = ST_LOAD;
        else           w_state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        w_enq  = i_tx_ready & i_spi_idle;
        w_data = f_seg_byte(r_seg, r_idx[3:0], r_line1, r_line2);
        w_last = (r_idx == (f_seg_len(r_seg) - 5'd1));
        if (w_enq && w_last) w_state_nxt = ST_GO;
        else                 w_state_nxt = ST_LOAD;
      end
      ST_GO: w_state_nxt = ST_START;
      ST_START: begin
        if (!i_spi_idle) w_state_nxt = ST_BUSY;
        else             w_state_nxt = ST_START;
      end
      ST_BUSY: begin
        if (i_spi_idle) w_state_nxt = ST_GAP;
        else            w_state_nxt = ST_BUSY;
      end
      ST_GAP: begin
        if (r_gap_cnt != '0)    w_state_nxt = ST_GAP;
        else if (r_seg == 3'd4) w_state_nxt = ST_IDLE;
        else                    w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Line latch, segment/byte indices, transaction length and gap counter
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_seg     <= 3'd0;
      r_idx     <= 5'd0;
      r_line1   <= '0;
      r_line2   <= '0;
      r_tx_len  <= 5'd0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cls_upd) begin
            r_line1 <= i_dat_ascii_line1;
            r_line2 <= i_dat_ascii_line2;
            r_seg   <= 3'd0;
            r_idx   <= 5'd0;
          end
        end
        ST_LOAD: begin
          if (w_enq && w_last) begin
            r_idx    <= 5'd0;
            r_tx_len <= f_seg_len(r_seg);
          end else if (w_enq) begin
            r_idx <= r_idx + 5'd1;
          end
        end
        ST_BUSY: begin
          if (i_spi_idle) r_gap_cnt <= GAP_LOAD;
        end
        ST_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end else if (r_seg != 3'd4) begin
            r_seg <= r_seg + 3'd1;
            r_idx <= 5'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_cls_ready  = (r_state == ST_IDLE);
  assign o_go_stand   = (r_state == ST_GO);
  assign o_tx_enqueue = w_enq;
  assign o_tx_data    = w_data;
  assign o_tx_len     = r_tx_len;

endmodule

// File: tb/tb_pmod_cls_text_sequencer.sv
// Randomized bench: a byte/length scoreboard built from the display command set,
// a simple SPI driver model, and gap/ready timing checks.
module tb_pmod_cls_text_sequencer;

  localparam int GAP = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         upd = 1'b0;
  logic [127:0] l1 = '0;
  logic [127:0] l2 = '0;
  logic         tx_ready = 1'b1;
  logic         spi_idle = 1'b1;
  logic         o_cls_ready, o_tx_enqueue, o_go_stand;
  logic [7:0]   o_tx_data;
  logic [4:0]   o_tx_len;

  pmod_cls_text_sequencer #(.MIN_GAP_CYCLES(GAP)) dut (
    .i_clk_20mhz       (clk),
    .i_rst_20mhz       (rst),
    .i_cls_upd         (upd),
    .i_dat_ascii_line1 (l1),
    .i_dat_ascii_line2 (l2),
    .o_cls_ready       (o_cls_ready),
    .o_tx_data         (o_tx_data),
    .o_tx_enqueue      (o_tx_enqueue),
    .o_go_stand        (o_go_stand),
    .o_tx_len          (o_tx_len),
    .i_tx_ready        (tx_ready),
    .i_spi_idle        (spi_idle)
  );

  always #25 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [4:0] exp_len_q[$];
  int         busy_len = 3;
  int         tx_mode = 0;
  bit         noise_on = 1'b0;
  bit         skip_ready = 1'b1;
  int         cyc = 0, rise_cyc = 0, seq_enq = 0, seq_go = 0;
  bit         seg_first = 1'b0;
  event       ev_go;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference stream: what the display must receive for one update
  task automatic push_expected(input logic [127:0] a, input logic [127:0] b);
    logic [7:0] clr[3]  = '{8'h1b, 8'h5b, 8'h6a};
    logic [7:0] row0[6] = '{8'h1b, 8'h5b, 8'h30, 8'h3b, 8'h30, 8'h48};
    logic [7:0] row1[6] = '{8'h1b, 8'h5b, 8'h31, 8'h3b, 8'h30, 8'h48};
    foreach (clr[i])  exp_q.push_back(clr[i]);
    foreach (row0[i]) exp_q.push_back(row0[i]);
    for (int i = 0; i < 16; i++) exp_q.push_back(a[127-8*i -: 8]);
    foreach (row1[i]) exp_q.push_back(row1[i]);
    for (int i = 0; i < 16; i++) exp_q.push_back(b[127-8*i -: 8]);
    exp_len_q.push_back(5'd3);
    exp_len_q.push_back(5'd6);
    exp_len_q.push_back(5'd16);
    exp_len_q.push_back(5'd6);
    exp_len_q.push_back(5'd16);
  endtask

  function automatic logic [127:0] rand_line();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'($urandom_range(32, 126));
    return r;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge
  initial begin
    logic prev_idle = 1'b1, prev_ready = 1'b1, prev_enq = 1'b0, prev_go = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (spi_idle && !prev_idle) rise_cyc = cyc;
        if (o_tx_enqueue) begin
          check_val("enq_gate", {31'd0, tx_ready & spi_idle}, 32'd1);
          if (exp_q.size() == 0) check_val("extra_enq", 32'd1, 32'd0);
          else                   check_val("tx_data", o_tx_data, exp_q.pop_front());
          if (seg_first && seq_go > 0 && tx_mode == 0)
            check_val("gap_to_load", cyc - rise_cyc, GAP + 1);
          seg_first = 1'b0;
          seq_enq++;
        end
        if (o_go_stand) begin
          check_val("go_after_last_enq", prev_enq, 1'b1);
          check_val("go_single_cycle", prev_go, 1'b0);
          if (exp_len_q.size() == 0) check_val("extra_go", 32'd1, 32'd0);
          else                       check_val("tx_len", o_tx_len, exp_len_q.pop_front());
          seq_go++;
          seg_first = 1'b1;
          -> ev_go;
        end
        if (o_cls_ready && !prev_ready && !skip_ready)
          check_val("gap_to_ready", cyc - rise_cyc, GAP + 1);
      end
      prev_idle  = spi_idle;
      prev_ready = o_cls_ready;
      prev_enq   = o_tx_enqueue;
      prev_go    = o_go_stand;
    end
  end

  // SPI driver model: goes busy the cycle after a go strobe
  initial begin
    forever begin
      @(ev_go);
      @(posedge clk); #1 spi_idle = 1'b0;
      repeat (busy_len) @(posedge clk);
      #1 spi_idle = 1'b1;
    end
  end

  // FIFO space model
  initial begin
    int k = 0;
    forever begin
      @(posedge clk); #1;
      k++;
      case (tx_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ($urandom_range(0, 3) != 0);
        default: tx_ready = (k % 3 != 0);
      endcase
    end
  end

  // Spurious update pulses while a sequence is in flight
  initial begin
    forever begin
      @(posedge clk); #2;
      if (noise_on && !o_cls_ready && $urandom_range(0, 5) == 0) begin
        upd = 1'b1;
        @(posedge clk); #1 upd = 1'b0;
      end
    end
  end

  task automatic run_update(input logic [127:0] a, input logic [127:0] b,
                            input bit check_first, input bit wait_done);
    int t;
    repeat (3) @(posedge clk);
    #1;
    t = 0;
    while (!o_cls_ready && t < 5000) begin @(posedge clk); #1; t++; end
    check_val("ready_before_req", o_cls_ready, 1'b1);
    push_expected(a, b);
    seq_enq = 0; seq_go = 0; seg_first = 1'b0;
    l1 = a; l2 = b; upd = 1'b1;
    @(posedge clk); #1;
    upd = 1'b0;
    l1 = rand_line(); l2 = rand_line();
    if (check_first) begin
      @(negedge clk);
      check_val("first_enq", o_tx_enqueue, 1'b1);
      check_val("first_byte", o_tx_data, 8'h1b);
      check_val("busy_not_ready", o_cls_ready, 1'b0);
    end
    if (wait_done) begin
      t = 0;
      while (!o_cls_ready && t < 5000) begin @(posedge clk); #1; t++; end
      check_val("seq_done", o_cls_ready, 1'b1);
      check_val("enq_total", seq_enq, 32'd47);
      check_val("go_total", seq_go, 32'd5);
      check_val("bytes_left", exp_q.size(), 32'd0);
    end
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", o_cls_ready, 1'b1);
    check_val("rst_enq", o_tx_enqueue, 1'b0);
    check_val("rst_go", o_go_stand, 1'b0);
    check_val("rst_len", o_tx_len, 5'd0);
    check_val("rst_data", o_tx_data, 8'h00);
    @(posedge clk); #1 rst = 1'b0;
    skip_ready = 1'b0;

    tx_mode = 0; busy_len = 3;
    run_update("Hello, World!   ", "0123456789ABCDEF", 1'b1, 1'b1);

    tx_mode = 2;
    run_update(rand_line(), rand_line(), 1'b0, 1'b1);

    tx_mode = 1; noise_on = 1'b1;
    run_update(rand_line(), rand_line(), 1'b0, 1'b1);
    noise_on = 1'b0;

    tx_mode = 0; busy_len = 50;
    run_update(rand_line(), rand_line(), 1'b1, 1'b1);
    busy_len = 3;

    run_update(rand_line(), rand_line(), 1'b1, 1'b0);
    t = 0;
    while (!(seq_go == 2 && seq_enq >= 14) && t < 2000) begin @(posedge clk); #1; t++; end
    check_val("reach_mid_s2", (seq_go == 2 && seq_enq >= 14), 1'b1);
    skip_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("abort_enq", o_tx_enqueue, 1'b0);
    check_val("abort_go", o_go_stand, 1'b0);
    check_val("abort_len", o_tx_len, 5'd0);
    check_val("abort_ready", o_cls_ready, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    exp_len_q.delete();
    skip_ready = 1'b0;
    run_update(rand_line(), rand_line(), 1'b1, 1'b1);

    for (int r = 0; r < 3; r++) begin
      busy_len = $urandom_range(1, 8);
      tx_mode  = $urandom_range(0, 1);
      run_update(rand_line(), rand_line(), 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
